// File: rtl/stacker_core.sv
// stacker_core: sweeping-block stacking game controller.
// Drives a row-addressed display writer and keeps a saturating score.
module stacker_core #(
  parameter int WIDTH       = 8,
  parameter int ROWS        = 8,
  parameter int BLOCK_INIT  = 3,
  parameter int PERIOD_INIT = 4,
  localparam int RW = $clog2(ROWS),
  localparam int SW = $clog2(WIDTH * ROWS + 1),
  localparam int PW = $clog2(PERIOD_INIT + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn,
  input  logic             tick,
  output logic [WIDTH-1:0] val,
  output logic [RW-1:0]    row_index,
  output logic             write_strobe,
  output logic             clr_array,
  output logic [SW-1:0]    score,
  output logic             game_over,
  output logic             win
);

  typedef enum logic [2:0] {
    S_INIT,
    S_TRACE,
    S_CHECK,
    S_UPDATE,
    S_WIN,
    S_LOSE
  } state_t;

  localparam logic [WIDTH-1:0] CUR_RST =
    ~({WIDTH{1'b1}} >> BLOCK_INIT);
  localparam logic [SW-1:0] SCORE_MAX = SW'(WIDTH * ROWS);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [31:0]   PI32      = 32'(PERIOD_INIT);

  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_cur, w_cur;
  logic [WIDTH-1:0] r_prev, w_prev;
  logic [WIDTH-1:0] r_locked, w_locked;
  logic             r_dir, w_dir;
  logic [PW-1:0]    r_div, w_div;
  logic             r_pend, w_pend;
  logic [WIDTH-1:0] r_val, w_val;
  logic [RW-1:0]    r_row, w_row;
  logic             r_ws, w_ws;
  logic [SW-1:0]    r_score, w_score;

  logic [WIDTH-1:0] w_mv;
  logic             w_mdir;
  logic             w_full;
  logic             w_req;
  logic [31:0]      w_row32;
  logic [PW-1:0]    w_last;
  logic [SW:0]      w_sum;
  logic [SW-1:0]    w_sat;

  function automatic logic [SW-1:0] popcnt(
    input logic [WIDTH-1:0] v
  );
    logic [SW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++)
      c = c + SW'(v[i]);
    return c;
  endfunction

  // Last divider count of a move: period is max(1, PERIOD_INIT-row).
  assign w_row32 = 32'(r_row);
  assign w_last  = (w_row32 < PI32) ?
                   PW'(PI32 - w_row32 - 32'd1) : '0;

  // Score accumulates locked cells and clamps at the full board.
  assign w_sum = {1'b0, r_score} + {1'b0, popcnt(r_locked)};
  assign w_sat = (w_sum > {1'b0, SCORE_MAX}) ?
                 SCORE_MAX : w_sum[SW-1:0];

  assign w_full = &r_cur;

  // One-cell move in dir, bouncing off either edge of the row.
  always_comb begin
    w_mv   = r_cur;
    w_mdir = r_dir;
    if (!r_dir) begin
      if (r_cur[0]) begin
        w_mv   = r_cur << 1;
        w_mdir = 1'b1;
      end else begin
        w_mv   = r_cur >> 1;
      end
    end else begin
      if (r_cur[WIDTH-1]) begin
        w_mv   = r_cur >> 1;
        w_mdir = 1'b0;
      end else begin
        w_mv   = r_cur << 1;
      end
    end
  end

  // Next state and datapath; a write colliding with the previous
  // cycle's strobe is parked in r_pend and issued one cycle later.
  always_comb begin
    w_state  = r_state;
    w_cur    = r_cur;
    w_prev   = r_prev;
    w_locked = r_locked;
    w_dir    = r_dir;
    w_div    = r_div;
    w_pend   = r_pend;
    w_val    = r_val;
    w_row    = r_row;
    w_ws     = 1'b0;
    w_score  = r_score;
    w_req    = 1'b0;
    case (r_state)
      S_INIT: begin
        w_cur   = CUR_RST;
        w_prev  = '1;
        w_dir   = 1'b0;
        w_div   = '0;
        w_row   = '0;
        w_score = '0;
        w_val   = CUR_RST;
        w_ws    = 1'b1;
        w_pend  = 1'b0;
        w_state = S_TRACE;
      end
      S_TRACE: begin
        if (btn) begin
          w_locked = r_cur & r_prev;
          w_div    = '0;
          w_ws     = r_pend;
          w_pend   = 1'b0;
          w_state  = S_CHECK;
        end else begin
          if (tick) begin
            if (r_div == w_last) begin
              w_div = '0;
              if (!w_full) begin
                w_cur = w_mv;
                w_dir = w_mdir;
                w_val = w_mv;
                w_req = 1'b1;
              end
            end else begin
              w_div = r_div + PW'(1);
            end
          end
          if (w_req || r_pend) begin
            w_ws   = !r_ws;
            w_pend = r_ws;
          end
        end
      end
      S_CHECK: begin
        if (!r_ws) begin
          if (r_locked == '0) begin
            w_state = S_LOSE;
          end else begin
            w_score = w_sat;
            w_val   = r_locked;
            w_ws    = 1'b1;
            w_state = (r_row == ROW_LAST) ?
                      S_WIN : S_UPDATE;
          end
        end
      end
      S_UPDATE: begin
        w_row   = r_row + RW'(1);
        w_prev  = r_locked;
        w_cur   = r_locked;
        w_val   = r_locked;
        w_pend  = 1'b1;
        w_state = S_TRACE;
      end
      S_WIN, S_LOSE: begin
        if (btn) w_state = S_INIT;
      end
      default: w_state = S_INIT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_INIT;
    else        r_state <= w_state;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur    <= CUR_RST;
      r_prev   <= '1;
      r_locked <= '0;
      r_dir    <= 1'b0;
      r_div    <= '0;
      r_pend   <= 1'b0;
      r_val    <= '0;
      r_row    <= '0;
      r_ws     <= 1'b0;
      r_score  <= '0;
    end else begin
      r_cur    <= w_cur;
      r_prev   <= w_prev;
      r_locked <= w_locked;
      r_dir    <= w_dir;
      r_div    <= w_div;
      r_pend   <= w_pend;
      r_val    <= w_val;
      r_row    <= w_row;
      r_ws     <= w_ws;
      r_score  <= w_score;
    end
  end

  assign val          = r_val;
  assign row_index    = r_row;
  assign write_strobe = r_ws;
  assign clr_array    = (r_state == S_INIT);
  assign score        = r_score;
  assign game_over    = (r_state == S_WIN) ||
                        (r_state == S_LOSE);
  assign win          = (r_state == S_WIN);

endmodule

// File: tb/tb_stacker_core.sv
// tb_stacker_core: directed and random play against an
// interval-based model of the stacking game and its display.
module tb_stacker_core;

  localparam int WIDTH = 8;
  localparam int ROWS  = 8;
  localparam int BI    = 3;
  localparam int PI    = 4;
  localparam int RW    = $clog2(ROWS);
  localparam int SW    = $clog2(WIDTH * ROWS + 1);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn = 1'b0;
  logic tick = 1'b0;
  logic [WIDTH-1:0] val;
  logic [RW-1:0] row_index;
  logic write_strobe, clr_array, game_over, win;
  logic [SW-1:0] score;

  stacker_core #(
    .WIDTH(WIDTH), .ROWS(ROWS),
    .BLOCK_INIT(BI), .PERIOD_INIT(PI)
  ) dut (
    .clk(clk), .reset(reset),
    .btn(btn), .tick(tick),
    .val(val), .row_index(row_index),
    .write_strobe(write_strobe),
    .clr_array(clr_array), .score(score),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // display as seen through the write port
  logic [WIDTH-1:0] disp [ROWS];
  int ws_double = 0;
  logic ws_prev = 1'b0;

  always @(negedge clk) begin
    if (clr_array) begin
      for (int i = 0; i < ROWS; i++) disp[i] <= '0;
    end else if (write_strobe) begin
      disp[row_index] <= val;
    end
    if (write_strobe && ws_prev) ws_double <= ws_double + 1;
    ws_prev <= write_strobe;
  end

  // model: block is the interval [lo, lo+w)
  int m_lo, m_w, m_plo, m_pw, m_dir, m_div;
  int m_row, m_score, m_st;
  logic [WIDTH-1:0] m_val;
  logic [WIDTH-1:0] mdisp [ROWS];

  function automatic logic [WIDTH-1:0] pat(
    input int lo, input int w
  );
    logic [31:0] p;
    p = ((32'd1 << w) - 32'd1) << lo;
    return p[WIDTH-1:0];
  endfunction

  task automatic m_init();
    m_lo = WIDTH - BI; m_w = BI;
    m_plo = 0; m_pw = WIDTH;
    m_dir = 0; m_div = 0;
    m_row = 0; m_score = 0; m_st = 0;
    for (int i = 0; i < ROWS; i++) mdisp[i] = '0;
    m_val = pat(m_lo, m_w);
    mdisp[0] = m_val;
  endtask

  task automatic m_tick();
    int per;
    if (m_st != 0) return;
    per = (PI - m_row > 1) ? PI - m_row : 1;
    if (m_div == per - 1) begin
      m_div = 0;
      if (m_w < WIDTH) begin
        if (m_dir == 0) begin
          if (m_lo == 0) begin m_dir = 1; m_lo = 1; end
          else m_lo--;
        end else begin
          if (m_lo + m_w == WIDTH) begin m_dir = 0; m_lo--; end
          else m_lo++;
        end
        m_val = pat(m_lo, m_w);
        mdisp[m_row] = m_val;
      end
    end else begin
      m_div++;
    end
  endtask

  task automatic m_btn();
    int lo2, hi2;
    if (m_st != 0) begin m_init(); return; end
    m_div = 0;
    lo2 = (m_lo > m_plo) ? m_lo : m_plo;
    hi2 = (m_lo + m_w < m_plo + m_pw) ?
          m_lo + m_w : m_plo + m_pw;
    if (hi2 <= lo2) begin m_st = 2; return; end
    m_lo = lo2; m_w = hi2 - lo2;
    m_score = m_score + m_w;
    if (m_score > WIDTH * ROWS) m_score = WIDTH * ROWS;
    m_val = pat(m_lo, m_w);
    mdisp[m_row] = m_val;
    if (m_row == ROWS - 1) begin
      m_st = 1;
    end else begin
      m_row++;
      m_plo = m_lo; m_pw = m_w;
      mdisp[m_row] = m_val;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".val"}, 32'(val), 32'(m_val));
    chk({tag, ".row"}, 32'(row_index), 32'(m_row));
    chk({tag, ".score"}, 32'(score), 32'(m_score));
    chk({tag, ".over"}, 32'(game_over), 32'(m_st != 0));
    chk({tag, ".win"}, 32'(win), 32'(m_st == 1));
    chk({tag, ".clr"}, 32'(clr_array), 32'd0);
    chk({tag, ".ws2"}, 32'(ws_double), 32'd0);
    for (int i = 0; i < ROWS; i++)
      chk($sformatf("%s.disp%0d", tag, i),
          32'(disp[i]), 32'(mdisp[i]));
  endtask

  task automatic clk1(input logic b, input logic t);
    btn = b; tick = t;
    @(posedge clk); #1;
    btn = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) clk1(1'b0, 1'b0);
  endtask

  task automatic tk(input int n);
    repeat (n) begin clk1(1'b0, 1'b1); m_tick(); end
    idle(3);
  endtask

  task automatic press();
    clk1(1'b1, 1'b0); m_btn(); idle(5);
  endtask

  task automatic press_tick();
    clk1(1'b1, 1'b1); m_btn(); idle(5);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    clk1(1'b0, 1'b0);
    m_init();
    idle(2);
  endtask

  initial begin
    int r;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.clr", 32'(clr_array), 32'd1);
    chk("rst.val", 32'(val), 32'd0);
    chk("rst.row", 32'(row_index), 32'd0);
    chk("rst.ws", 32'(write_strobe), 32'd0);
    chk("rst.score", 32'(score), 32'd0);
    chk("rst.over", 32'(game_over), 32'd0);
    reset = 1'b1;
    chk("rel.clr", 32'(clr_array), 32'd1);
    clk1(1'b0, 1'b0);
    m_init();
    chk("init.ws", 32'(write_strobe), 32'd1);
    chk("init.val", 32'(val), 32'hE0);
    chk("init.clr", 32'(clr_array), 32'd0);
    idle(2);
    check_all("init");

    tk(4);
    chk("a.t4", 32'(val), 32'h70);
    check_all("a.t4");
    press();
    chk("a.p0.score", 32'(score), 32'd3);
    chk("a.p0.row", 32'(row_index), 32'd1);
    chk("a.p0.disp0", 32'(disp[0]), 32'h70);
    tk(2);
    chk("a.r1.t2", 32'(val), 32'h70);
    tk(1);
    chk("a.r1.t3", 32'(val), 32'h38);
    press();
    chk("a.p1.score", 32'(score), 32'd5);
    chk("a.p1.row", 32'(row_index), 32'd2);
    chk("a.p1.disp1", 32'(disp[1]), 32'h30);
    check_all("a.p1");

    do_reset();
    tk(4);
    chk("b.t4", 32'(val), 32'h70);
    tk(16);
    chk("b.t20", 32'(val), 32'h07);
    tk(4);
    chk("b.bounce", 32'(val), 32'h0E);
    tk(4);
    chk("b.left", 32'(val), 32'h1C);
    check_all("b");

    do_reset();
    press();
    tk(2);
    press_tick();
    chk("c.val", 32'(val), 32'hE0);
    chk("c.score", 32'(score), 32'd6);
    chk("c.row", 32'(row_index), 32'd2);
    check_all("c");

    do_reset();
    press();
    tk(15);
    chk("d.val", 32'(val), 32'h07);
    press();
    chk("d.over", 32'(game_over), 32'd1);
    chk("d.win", 32'(win), 32'd0);
    chk("d.score", 32'(score), 32'd3);
    tk(3);
    check_all("d.lose");
    press();
    chk("d.rst.score", 32'(score), 32'd0);
    chk("d.rst.over", 32'(game_over), 32'd0);
    check_all("d.restart");

    repeat (8) press();
    chk("e.score", 32'(score), 32'd24);
    chk("e.over", 32'(game_over), 32'd1);
    chk("e.win", 32'(win), 32'd1);
    check_all("e.win");
    press();
    repeat (4) press();
    tk(2);
    check_all("e.row4");
    reset = 1'b0;
    #1;
    chk("e.mid.clr", 32'(clr_array), 32'd1);
    chk("e.mid.val", 32'(val), 32'd0);
    chk("e.mid.row", 32'(row_index), 32'd0);
    chk("e.mid.score", 32'(score), 32'd0);
    chk("e.mid.ws", 32'(write_strobe), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    clk1(1'b0, 1'b0);
    m_init();
    idle(2);
    check_all("e.after");

    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        press();
      end else if (r == 1) begin
        press_tick();
      end else begin
        clk1(1'b0, 1'b1);
        m_tick();
        idle(int'($urandom_range(0, 2)));
      end
      if (it % 10 == 9) begin
        idle(3);
        check_all($sformatf("rnd%0d", it));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stacker_core.md
Name: stacker_core

Overview:
- Parametrised successor to the single-row-width stacking game controller.
- A block of lit cells sweeps back and forth across a WIDTH-cell row. A button press locks it and trims it against the row below. The game continues for ROWS rows, ending in WIN or LOSE.
- Adds configurable row width, depth and initial block width, a per-level speed-up, and a running score.
- Sits between the debounced button/tick generators and the display-array writer (val / row_index / write_strobe / clr_array).

Parameters:
- WIDTH, 8, cells per row (≥2).
- ROWS, 8, number of rows to stack (≥2).
- BLOCK_INIT, 3, lit cells in the first row (1..WIDTH).
- PERIOD_INIT, 4, ticks per one-cell move on row 0. Period on row r is max(1, PERIOD_INIT−r).
- Derived localparams:
  - RW = clog2(ROWS).
  - SW = clog2(WIDTH·ROWS+1).
  - PW = clog2(PERIOD_INIT+1).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous, active-low reset.
- btn, input, 1, debounced single-cycle press pulse.
- tick, input, 1, single-cycle sweep-rate pulse.
- val, output, WIDTH, row pattern to write.
- row_index, output, RW, row being played/written.
- write_strobe, output, 1, one-cycle write of val at row_index.
- clr_array, output, 1, clear display array; high exactly while in INIT.
- score, output, SW, total cells locked so far.
- game_over, output, 1, high in WIN or LOSE.
- win, output, 1, high in WIN only.

Behaviour:
- States: INIT, TRACE, CHECK, UPDATE, WIN, LOSE. All registers are asynchronously forced to reset values while reset=0.
- Reset values:
  - state=INIT.
  - val=0, row_index=0, write_strobe=0, score=0.
  - cur = BLOCK_INIT ones in the MSBs. prev = all ones.
  - dir=RIGHT (toward bit 0). div_cnt=0.
  - clr_array=1 (combinational from INIT).
- INIT, one cycle:
  - Load cur, prev, dir, div_cnt and row_index to the reset values. Clear score.
  - Set val=cur, pulse write_strobe. Go to TRACE.
- TRACE, on tick with no btn:
  - If div_cnt == period−1: div_cnt=0 and move one cell in dir. Otherwise div_cnt++.
  - Bounce rule: if the move would shift a 1 out of the row (cur[0]=1 moving RIGHT, cur[WIDTH−1]=1 moving LEFT), flip dir and move one cell the other way in the same cycle.
  - If the block width equals WIDTH, no move occurs.
  - Every move sets val=new cur and pulses write_strobe the next cycle.
- TRACE, on btn:
  - locked = cur & prev. div_cnt=0. Go to CHECK.
  - btn has priority over a same-cycle tick: no move happens.
- CHECK:
  - If locked == 0: go to LOSE (score unchanged).
  - Otherwise: score += popcount(locked); val=locked; pulse write_strobe at the current row_index.
  - Then, if row_index == ROWS−1, go to WIN. Otherwise go to UPDATE.
- UPDATE:
  - row_index++, prev=locked, cur=locked. dir and position are kept.
  - val=cur, pulse write_strobe at the new row_index. Go to TRACE.
- WIN / LOSE:
  - Hold all outputs. btn returns to INIT. tick is ignored.
- btn is ignored in CHECK, UPDATE and INIT.
- write_strobe is never high for two consecutive cycles.
- Reset asserted mid-game returns to INIT values immediately. After release, the first edge executes INIT.
- score saturates at its maximum, WIDTH·ROWS; no wrap.
- Unreachable state encodings recover to INIT on the next clock.

Test Plan:
- Reset release (defaults) → clr_array=1 for one cycle; val=8'b11100000 written at row 0; score=0.
- 4 ticks in TRACE → val=8'b01110000. 16 further ticks → 8'b00000111. 4 more ticks → bounce, val=8'b00001110, dir=LEFT.
- Press btn at 8'b01110000 on row 0 → score=3, row 0 written 8'b01110000, row_index=1. Then press at 8'b00111000 → locked=8'b00110000, score=5, row_index=2.
- Row 1, period 3: verify 3 ticks per move. btn coincident with the 3rd tick → no move; locked taken from the pre-tick pattern.
- Press on row 1 with cur disjoint from prev (e.g. prev=8'b11100000, cur=8'b00000111) → LOSE, game_over=1, win=0, score unchanged. Next btn → INIT, score=0.
- Eight aligned presses at 8'b11100000 (no ticks) → WIN after row 7, score=24, game_over=1, win=1. Pull reset low mid-row-4 → immediate INIT values.
